// File: rtl/spi_pkg.sv
// -----------------------------------------------------------------------------
// spi_pkg
// Shared definitions for the DAC/PLL command path: the serializer FSM state
// encoding, frame/command widths, and the command-byte values the upstream
// controller places in the top byte of each 24-bit frame.
// -----------------------------------------------------------------------------
package spi_pkg;

   localparam int FRAME_W   = 24;
   localparam int FRAME_CNT = 4;
   localparam int CMD_W     = FRAME_W * FRAME_CNT;

   // Command bytes (frame bits [23:16]) emitted by the upstream controller.
   localparam logic [7:0] CMD_DAC_WRITE = 8'h11;
   localparam logic [7:0] CMD_PLL_WRITE = 8'h14;
   localparam logic [7:0] CMD_PLL_LOAD  = 8'h25;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SETUP,
      ST_LOW,
      ST_HIGH,
      ST_HOLD,
      ST_GAP
   } spi_state_e;

endpackage

// File: rtl/spi_frame_shifter.sv
// -----------------------------------------------------------------------------
// spi_frame_shifter
// Shifts one FRAME_WIDTH-bit frame out MSB first in SPI mode 0 and then holds
// cs_n high for GAP_CYCLES. The parent decides what follows the gap by
// asserting start on the last GAP cycle (or any IDLE cycle).
//
// Ports:
//   aclk, areset   clock, synchronous active-high reset
//   start          load frame and begin SETUP (only honoured in IDLE / GAP end)
//   frame          frame to transmit, sampled when start is high
//   state          current FSM state
//   gap_last       final cycle of GAP
//   spi_sclk/mosi/cs_n  SPI bus
// -----------------------------------------------------------------------------
module spi_frame_shifter
   import spi_pkg::*;
#(
   parameter int FRAME_WIDTH = FRAME_W,
   parameter int CLK_DIV     = 4,
   parameter int GAP_CYCLES  = 8
) (
   input  logic                   aclk,
   input  logic                   areset,
   input  logic                   start,
   input  logic [FRAME_WIDTH-1:0] frame,
   output spi_state_e             state,
   output logic                   gap_last,
   output logic                   spi_sclk,
   output logic                   spi_mosi,
   output logic                   spi_cs_n
);

   localparam int CNT_MAX = (CLK_DIV > GAP_CYCLES) ? CLK_DIV : GAP_CYCLES;
   localparam int DIV_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
   localparam int BIT_W   = $clog2(FRAME_WIDTH);

   spi_state_e             state_q, state_d;
   logic [DIV_W-1:0]       div_q, div_d;
   logic [BIT_W-1:0]       bit_q, bit_d;
   logic [FRAME_WIDTH-1:0] frame_q;
   logic                   div_last;
   logic                   in_frame;

   assign div_last = (div_q == DIV_W'(CLK_DIV - 1));
   assign gap_last = (state_q == ST_GAP) && (div_q == DIV_W'(GAP_CYCLES - 1));

   always_ff @(posedge aclk) begin
      if (areset) begin
         state_q <= ST_IDLE;
         div_q   <= '0;
         bit_q   <= '0;
      end else begin
         state_q <= state_d;
         div_q   <= div_d;
         bit_q   <= bit_d;
      end
   end

   always_ff @(posedge aclk) begin
      if (start) frame_q <= frame;
   end

   // Divider restarts at 0 on every phase change; the bit counter steps on
   // HIGH->LOW so mosi presents the next bit for the whole LOW phase.
   always_comb begin
      state_d = state_q;
      div_d   = div_q + 1'b1;
      bit_d   = bit_q;
      case (state_q)
         ST_IDLE: begin
            div_d = '0;
            if (start) begin
               state_d = ST_SETUP;
               bit_d   = BIT_W'(FRAME_WIDTH - 1);
            end
         end
         ST_SETUP: begin
            if (div_last) begin
               state_d = ST_HIGH;
               div_d   = '0;
            end
         end
         ST_HIGH: begin
            if (div_last) begin
               div_d = '0;
               if (bit_q == '0) begin
                  state_d = ST_HOLD;
               end else begin
                  state_d = ST_LOW;
                  bit_d   = bit_q - 1'b1;
               end
            end
         end
         ST_LOW: begin
            if (div_last) begin
               state_d = ST_HIGH;
               div_d   = '0;
            end
         end
         ST_HOLD: begin
            if (div_last) begin
               state_d = ST_GAP;
               div_d   = '0;
            end
         end
         ST_GAP: begin
            if (gap_last) begin
               div_d = '0;
               if (start) begin
                  state_d = ST_SETUP;
                  bit_d   = BIT_W'(FRAME_WIDTH - 1);
               end else begin
                  state_d = ST_IDLE;
               end
            end
         end
         default: begin
            state_d = ST_IDLE;
            div_d   = '0;
         end
      endcase
   end

   assign in_frame = (state_q == ST_SETUP) || (state_q == ST_LOW) ||
                     (state_q == ST_HIGH)  || (state_q == ST_HOLD);
   assign state    = state_q;
   assign spi_cs_n = ~in_frame;
   assign spi_sclk = (state_q == ST_HIGH);
   assign spi_mosi = in_frame & frame_q[bit_q];

endmodule

// File: rtl/axis_spi_serializer.sv
// -----------------------------------------------------------------------------
// axis_spi_serializer
// Accepts FRAME_COUNT x FRAME_WIDTH command words and sends every non-zero
// frame (frame 0 first) as its own chip-select transaction. One word can wait
// in a holding buffer while another is being sent; a word arriving while the
// buffer is full is dropped and flagged in sts_overrun.
//
// Ports:
//   aclk, areset     clock, synchronous active-high reset
//   s_axis_tdata     command word, frame k at [FW*k +: FW]
//   s_axis_tvalid    single-cycle word strobe (no backpressure upstream)
//   s_axis_tready    holding buffer empty (informational)
//   cfg_clr          clears sts_overrun (a same-cycle drop wins)
//   spi_sclk/mosi/cs_n  3-wire SPI, mode 0, MSB first
//   sts_busy         transfer in progress or buffer occupied
//   sts_overrun      sticky dropped-word flag
// -----------------------------------------------------------------------------
module axis_spi_serializer
   import spi_pkg::*;
#(
   parameter int FRAME_WIDTH = FRAME_W,
   parameter int FRAME_COUNT = FRAME_CNT,
   parameter int CLK_DIV     = 4,
   parameter int GAP_CYCLES  = 8
) (
   input  logic                               aclk,
   input  logic                               areset,
   input  logic [FRAME_WIDTH*FRAME_COUNT-1:0] s_axis_tdata,
   input  logic                               s_axis_tvalid,
   output logic                               s_axis_tready,
   input  logic                               cfg_clr,
   output logic                               spi_sclk,
   output logic                               spi_mosi,
   output logic                               spi_cs_n,
   output logic                               sts_busy,
   output logic                               sts_overrun
);

   localparam int WORD_W = FRAME_WIDTH * FRAME_COUNT;
   localparam int IDX_W  = (FRAME_COUNT > 1) ? $clog2(FRAME_COUNT) : 1;

   function automatic logic [FRAME_COUNT-1:0] nz_mask(input logic [WORD_W-1:0] w);
      nz_mask = '0;
      for (int k = 0; k < FRAME_COUNT; k++) begin
         nz_mask[k] = |w[k*FRAME_WIDTH +: FRAME_WIDTH];
      end
   endfunction

   logic [WORD_W-1:0]      act_word, buf_word, src_word;
   logic [FRAME_COUNT-1:0] act_mask, buf_mask, src_mask;
   logic                   buf_full, overrun;
   spi_state_e             state;
   logic                   gap_last;
   logic                   launch_ok, promote, start;
   logic                   take_direct, take_buf, drop;
   logic [IDX_W-1:0]       sel_idx;
   logic                   sel_found;
   logic [FRAME_WIDTH-1:0] start_frame;

   // A new frame may launch from IDLE or on the last GAP cycle. When the
   // active word has no frames left, the buffered word is promoted and its
   // first frame launches in the same cycle.
   assign launch_ok = (state == ST_IDLE) || gap_last;
   assign promote   = launch_ok && (act_mask == '0) && buf_full;
   assign src_word  = promote ? buf_word : act_word;
   assign src_mask  = promote ? buf_mask : act_mask;

   // Lowest pending non-zero frame; zero frames never enter the mask.
   always_comb begin
      sel_idx   = '0;
      sel_found = 1'b0;
      for (int k = FRAME_COUNT - 1; k >= 0; k--) begin
         if (src_mask[k]) begin
            sel_idx   = IDX_W'(k);
            sel_found = 1'b1;
         end
      end
   end

   assign start       = launch_ok && sel_found;
   assign start_frame = src_word[int'(sel_idx)*FRAME_WIDTH +: FRAME_WIDTH];

   assign take_direct = s_axis_tvalid && (state == ST_IDLE) && (act_mask == '0) && !buf_full;
   assign take_buf    = s_axis_tvalid && !take_direct && !buf_full;
   assign drop        = s_axis_tvalid && buf_full;

   always_ff @(posedge aclk) begin
      if (areset) begin
         act_mask <= '0;
         buf_mask <= '0;
         buf_full <= 1'b0;
         overrun  <= 1'b0;
      end else begin
         if (take_direct) begin
            act_mask <= nz_mask(s_axis_tdata);
         end else if (start) begin
            act_mask <= src_mask & ~(FRAME_COUNT'(1) << sel_idx);
         end else if (promote) begin
            act_mask <= '0;
         end

         if (take_buf) begin
            buf_mask <= nz_mask(s_axis_tdata);
            buf_full <= 1'b1;
         end else if (promote) begin
            buf_full <= 1'b0;
         end

         if (drop)         overrun <= 1'b1;
         else if (cfg_clr) overrun <= 1'b0;
      end
   end

   always_ff @(posedge aclk) begin
      if (take_direct)  act_word <= s_axis_tdata;
      else if (promote) act_word <= buf_word;
      if (take_buf)     buf_word <= s_axis_tdata;
   end

   spi_frame_shifter #(
      .FRAME_WIDTH (FRAME_WIDTH),
      .CLK_DIV     (CLK_DIV),
      .GAP_CYCLES  (GAP_CYCLES)
   ) u_shifter (
      .aclk     (aclk),
      .areset   (areset),
      .start    (start),
      .frame    (start_frame),
      .state    (state),
      .gap_last (gap_last),
      .spi_sclk (spi_sclk),
      .spi_mosi (spi_mosi),
      .spi_cs_n (spi_cs_n)
   );

   assign s_axis_tready = !areset && !buf_full;
   assign sts_busy      = (state != ST_IDLE) || buf_full;
   assign sts_overrun   = overrun;

endmodule

// File: tb/tb_axis_spi_serializer.sv
// -----------------------------------------------------------------------------
// tb_axis_spi_serializer
// Directed stimulus pushes the expected SPI frames into a queue; an
// independent bus monitor reassembles each cs_n transaction and compares it
// with the head of the queue.
// -----------------------------------------------------------------------------
module tb_axis_spi_serializer;

   localparam int FW       = 24;
   localparam int FC       = 4;
   localparam int CLK_DIV  = 4;
   localparam int GAP      = 8;
   localparam int CS_LOW   = (2*FW + 1) * CLK_DIV;   // 196

   logic             aclk = 1'b0;
   logic             areset;
   logic [FW*FC-1:0] s_axis_tdata;
   logic             s_axis_tvalid;
   logic             s_axis_tready;
   logic             cfg_clr;
   logic             spi_sclk, spi_mosi, spi_cs_n;
   logic             sts_busy, sts_overrun;

   axis_spi_serializer #(
      .FRAME_WIDTH (FW),
      .FRAME_COUNT (FC),
      .CLK_DIV     (CLK_DIV),
      .GAP_CYCLES  (GAP)
   ) dut (
      .aclk          (aclk),
      .areset        (areset),
      .s_axis_tdata  (s_axis_tdata),
      .s_axis_tvalid (s_axis_tvalid),
      .s_axis_tready (s_axis_tready),
      .cfg_clr       (cfg_clr),
      .spi_sclk      (spi_sclk),
      .spi_mosi      (spi_mosi),
      .spi_cs_n      (spi_cs_n),
      .sts_busy      (sts_busy),
      .sts_overrun   (sts_overrun)
   );

   always #5 aclk = ~aclk;

   typedef struct {
      logic [FW-1:0] val;
      bit            gap_chk;
   } exp_t;

   exp_t exp_q[$];
   int   checks = 0;
   int   errors = 0;
   bit   ignore_frame = 1'b0;

   task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
      end
   endtask

   task automatic expect_frame(input logic [FW-1:0] v, input bit gap_chk);
      exp_t e;
      e.val     = v;
      e.gap_chk = gap_chk;
      exp_q.push_back(e);
   endtask

   task automatic send(input logic [FW*FC-1:0] w);
      @(negedge aclk);
      s_axis_tdata  = w;
      s_axis_tvalid = 1'b1;
      @(negedge aclk);
      s_axis_tvalid = 1'b0;
   endtask

   task automatic wait_done(input string name, input int limit);
      for (int i = 0; i < limit; i++) begin
         @(negedge aclk);
         if (!sts_busy && exp_q.size() == 0) break;
      end
      chk({name, "_pending_frames"}, 64'(exp_q.size()), 64'd0);
      chk({name, "_busy_end"}, 64'(sts_busy), 64'd0);
   endtask

   // ---------------- bus monitor ----------------
   initial begin
      bit            prev_cs = 1'b1;
      bit            prev_sclk = 1'b0;
      int            low_cnt = 0, gap_cnt = 0, nbits = 0, hi_run = 0, lo_run = 0;
      bit            bad_period = 1'b0;
      logic [FW-1:0] shreg = '0;
      exp_t          e;
      forever begin
         @(negedge aclk);
         if (!spi_cs_n) begin
            if (prev_cs) begin
               if (exp_q.size() > 0 && exp_q[0].gap_chk)
                  chk("gap_cycles", 64'(gap_cnt), 64'(GAP));
               low_cnt = 0; nbits = 0; hi_run = 0; lo_run = 0;
               bad_period = 1'b0; shreg = '0;
            end
            low_cnt++;
            if (spi_sclk) begin
               if (!prev_sclk) begin
                  if (lo_run != CLK_DIV) bad_period = 1'b1;
                  shreg  = {shreg[FW-2:0], spi_mosi};
                  nbits++;
                  hi_run = 0;
               end
               hi_run++;
            end else begin
               if (prev_sclk) begin
                  if (hi_run != CLK_DIV) bad_period = 1'b1;
                  lo_run = 0;
               end
               lo_run++;
            end
         end else begin
            if (!prev_cs) begin
               if (ignore_frame) begin
                  ignore_frame = 1'b0;
               end else if (exp_q.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL unexpected_frame: got 0x%0h expected no frame", shreg);
               end else begin
                  e = exp_q.pop_front();
                  chk("frame_value", 64'(shreg), 64'(e.val));
                  chk("cs_low_cycles", 64'(low_cnt), 64'(CS_LOW));
                  chk("bit_count", 64'(nbits), 64'(FW));
                  chk("sclk_half_period", 64'(bad_period), 64'd0);
               end
               gap_cnt = 0;
            end
            gap_cnt++;
            if (spi_sclk) chk("sclk_outside_cs", 64'(spi_sclk), 64'd0);
         end
         prev_cs   = spi_cs_n;
         prev_sclk = spi_sclk;
      end
   end

   // ---------------- stimulus ----------------
   initial begin
      int  cnt;
      bit  seen_cs, seen_sclk, seen_notready;
      bit  prev_sclk;
      areset        = 1'b1;
      s_axis_tdata  = '0;
      s_axis_tvalid = 1'b0;
      cfg_clr       = 1'b0;
      repeat (3) @(negedge aclk);

      // Reset state
      chk("rst_cs_n", 64'(spi_cs_n), 64'd1);
      chk("rst_sclk", 64'(spi_sclk), 64'd0);
      chk("rst_mosi", 64'(spi_mosi), 64'd0);
      chk("rst_busy", 64'(sts_busy), 64'd0);
      chk("rst_overrun", 64'(sts_overrun), 64'd0);
      chk("rst_tready", 64'(s_axis_tready), 64'd0);
      areset = 1'b0;
      @(negedge aclk);
      chk("tready_after_rst", 64'(s_axis_tready), 64'd1);

      // Three non-zero frames, frame 3 skipped; busy spans 3*(196+8) cycles
      expect_frame(24'h111234, 1'b0);
      expect_frame(24'h14ABCD, 1'b1);
      expect_frame(24'h250000, 1'b1);
      send(96'h000000_250000_14ABCD_111234);
      cnt = 0;
      for (int i = 0; i < 3000; i++) begin
         @(negedge aclk);
         if (sts_busy) cnt++;
         else if (cnt > 0) break;
      end
      chk("busy_cycles_word_a", 64'(cnt), 64'(3 * (CS_LOW + GAP)));
      wait_done("word_a", 100);

      // All-zero word: consumed without bus activity
      send('0);
      cnt = 0; seen_cs = 0; seen_sclk = 0; seen_notready = 0;
      for (int i = 0; i < 20; i++) begin
         if (sts_busy)       cnt++;
         if (!spi_cs_n)      seen_cs = 1;
         if (spi_sclk)       seen_sclk = 1;
         if (!s_axis_tready) seen_notready = 1;
         @(negedge aclk);
      end
      chk("zero_word_busy_le1", 64'(cnt > 1), 64'd0);
      chk("zero_word_cs_activity", 64'(seen_cs), 64'd0);
      chk("zero_word_sclk_activity", 64'(seen_sclk), 64'd0);
      chk("zero_word_tready_drop", 64'(seen_notready), 64'd0);

      // Buffering, overrun on third word, clear
      expect_frame(24'hA5A5A5, 1'b0);
      expect_frame(24'h000001, 1'b1);
      expect_frame(24'h5A5A5A, 1'b1);
      expect_frame(24'hFFFFFF, 1'b1);
      send(96'h000000_000001_000000_A5A5A5);
      repeat (10) @(negedge aclk);
      send(96'hFFFFFF_000000_000000_5A5A5A);
      chk("buffered_tready", 64'(s_axis_tready), 64'd0);
      chk("buffered_busy", 64'(sts_busy), 64'd1);
      chk("no_overrun_yet", 64'(sts_overrun), 64'd0);
      send(96'h000000_000000_000000_DEAD01);
      chk("overrun_set", 64'(sts_overrun), 64'd1);
      @(negedge aclk);
      cfg_clr = 1'b1;
      @(negedge aclk);
      cfg_clr = 1'b0;
      chk("overrun_cleared", 64'(sts_overrun), 64'd0);
      wait_done("buffered", 2000);
      chk("tready_after_drain", 64'(s_axis_tready), 64'd1);

      // cfg_clr coincident with a drop: overrun stays set
      expect_frame(24'h000100, 1'b0);
      expect_frame(24'h000200, 1'b1);
      send(96'h000000_000000_000000_000100);
      repeat (5) @(negedge aclk);
      send(96'h000000_000000_000000_000200);
      @(negedge aclk);
      s_axis_tdata  = 96'h000000_000000_000000_000300;
      s_axis_tvalid = 1'b1;
      cfg_clr       = 1'b1;
      @(negedge aclk);
      s_axis_tvalid = 1'b0;
      cfg_clr       = 1'b0;
      chk("overrun_beats_clr", 64'(sts_overrun), 64'd1);
      @(negedge aclk);
      cfg_clr = 1'b1;
      @(negedge aclk);
      cfg_clr = 1'b0;
      chk("overrun_clr_alone", 64'(sts_overrun), 64'd0);
      wait_done("clr_vs_drop", 1000);

      // Bit-level pattern: MSB and LSB set
      expect_frame(24'h800001, 1'b0);
      send(96'h000000_000000_000000_800001);
      wait_done("bit_pattern", 400);

      // Reset in the middle of frame 0
      ignore_frame = 1'b1;
      send(96'h000000_000000_123456_C3C3C3);
      cnt = 0;
      prev_sclk = 1'b0;
      for (int i = 0; i < 500 && cnt < 10; i++) begin
         @(negedge aclk);
         if (spi_sclk && !prev_sclk) cnt++;
         prev_sclk = spi_sclk;
      end
      chk("reached_sclk_edge_10", 64'(cnt), 64'd10);
      areset = 1'b1;
      @(negedge aclk);
      chk("midrst_cs_n", 64'(spi_cs_n), 64'd1);
      chk("midrst_sclk", 64'(spi_sclk), 64'd0);
      chk("midrst_busy", 64'(sts_busy), 64'd0);
      chk("midrst_tready", 64'(s_axis_tready), 64'd0);
      areset = 1'b0;
      repeat (20) @(negedge aclk);
      chk("midrst_no_resume", 64'(spi_cs_n), 64'd1);
      expect_frame(24'h3C3C3C, 1'b0);
      send(96'h000000_000000_000000_3C3C3C);
      wait_done("after_reset", 400);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
